// File: rtl/io_interval_timer_if.sv
// rtl/io_interval_timer_if.sv - word-wide IO bus shared between the processor and its peripherals
interface io_bus_interface;
    logic        write_en;
    logic        read_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport slave  (input write_en, read_en, address, write_data, output read_data);
    modport master (output write_en, read_en, address, write_data, input read_data);
endinterface

// File: rtl/io_interval_timer.sv
// rtl/io_interval_timer.sv - prescaled down-counting interval timer with one-shot/periodic modes
module io_interval_timer #(
    parameter logic [31:0] BASE_ADDRESS = 32'h240
) (
    input  logic           clk,
    input  logic           reset,
    io_bus_interface.slave io_bus,
    output logic           timer_interrupt
);
    localparam logic [31:0] ADDR_CTRL     = BASE_ADDRESS;
    localparam logic [31:0] ADDR_RELOAD   = BASE_ADDRESS + 32'h04;
    localparam logic [31:0] ADDR_COUNT    = BASE_ADDRESS + 32'h08;
    localparam logic [31:0] ADDR_PRESCALE = BASE_ADDRESS + 32'h0C;
    localparam logic [31:0] ADDR_STATUS   = BASE_ADDRESS + 32'h10;

    logic        enable_q, enable_d;
    logic        periodic_q, periodic_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] reload_q, reload_d;
    logic [31:0] count_q, count_d;
    logic [15:0] prescale_q, prescale_d;
    logic        pending_q, pending_d;
    logic [15:0] presc_cnt_q, presc_cnt_d;
    logic [31:0] read_data_q, read_data_d;

    logic        wr_ctrl, wr_reload, wr_count, wr_prescale, wr_status;
    logic        tick, expire;
    logic [31:0] rd_mux;

    assign wr_ctrl     = io_bus.write_en && (io_bus.address == ADDR_CTRL);
    assign wr_reload   = io_bus.write_en && (io_bus.address == ADDR_RELOAD);
    assign wr_count    = io_bus.write_en && (io_bus.address == ADDR_COUNT);
    assign wr_prescale = io_bus.write_en && (io_bus.address == ADDR_PRESCALE);
    assign wr_status   = io_bus.write_en && (io_bus.address == ADDR_STATUS);

    // Equality compare: a prescaler already past a newly lowered PRESCALE runs on through 16'hFFFF.
    assign tick = enable_q && (presc_cnt_q == prescale_q);

    always_comb begin
        enable_d    = enable_q;
        periodic_d  = periodic_q;
        irq_en_d    = irq_en_q;
        reload_d    = reload_q;
        count_d     = count_q;
        prescale_d  = prescale_q;
        pending_d   = pending_q;
        presc_cnt_d = presc_cnt_q + 16'd1;
        expire      = 1'b0;

        if (!enable_q || tick || wr_ctrl) begin
            presc_cnt_d = '0;
        end

        // A software COUNT write takes priority over the tick for this cycle.
        if (wr_count) begin
            count_d = io_bus.write_data;
        end else if (tick) begin
            if (count_q > 32'd1) begin
                count_d = count_q - 32'd1;
            end else begin
                expire = 1'b1;
                if (periodic_q) begin
                    count_d = reload_q;
                end else begin
                    count_d  = '0;
                    enable_d = 1'b0;
                end
            end
        end

        if (wr_ctrl) begin
            enable_d   = io_bus.write_data[0];
            periodic_d = io_bus.write_data[1];
            irq_en_d   = io_bus.write_data[2];
        end
        if (wr_reload) begin
            reload_d = io_bus.write_data;
        end
        if (wr_prescale) begin
            prescale_d = io_bus.write_data[15:0];
        end
        if (wr_status && io_bus.write_data[0]) begin
            pending_d = 1'b0;
        end
        if (expire) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (io_bus.address)
            ADDR_CTRL:     rd_mux = {29'd0, irq_en_q, periodic_q, enable_q};
            ADDR_RELOAD:   rd_mux = reload_q;
            ADDR_COUNT:    rd_mux = count_q;
            ADDR_PRESCALE: rd_mux = {16'd0, prescale_q};
            ADDR_STATUS:   rd_mux = {31'd0, pending_q};
            default:       rd_mux = '0;
        endcase
        read_data_d = io_bus.read_en ? rd_mux : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q    <= 1'b0;
            periodic_q  <= 1'b0;
            irq_en_q    <= 1'b0;
            reload_q    <= '0;
            count_q     <= '0;
            prescale_q  <= '0;
            pending_q   <= 1'b0;
            presc_cnt_q <= '0;
            read_data_q <= '0;
        end else begin
            enable_q    <= enable_d;
            periodic_q  <= periodic_d;
            irq_en_q    <= irq_en_d;
            reload_q    <= reload_d;
            count_q     <= count_d;
            prescale_q  <= prescale_d;
            pending_q   <= pending_d;
            presc_cnt_q <= presc_cnt_d;
            read_data_q <= read_data_d;
        end
    end

    assign io_bus.read_data = read_data_q;
    assign timer_interrupt  = pending_q & irq_en_q;
endmodule

// File: tb/tb_io_interval_timer.sv
// tb/tb_io_interval_timer.sv - self-checking bench for io_interval_timer with a behavioural reference model
module tb_io_interval_timer;
    localparam logic [31:0] B = 32'h240;

    logic clk = 1'b0;
    logic reset;
    logic timer_interrupt;

    io_bus_interface bus();

    io_interval_timer #(.BASE_ADDRESS(B)) dut (
        .clk             (clk),
        .reset           (reset),
        .io_bus          (bus),
        .timer_interrupt (timer_interrupt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state, advanced once per rising edge.
    bit          m_en, m_per, m_irq, m_pend;
    logic [31:0] m_reload, m_count, m_rd;
    logic [15:0] m_pres, m_phase;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a == B)          return {29'd0, m_irq, m_per, m_en};
        if (a == B + 32'h04) return m_reload;
        if (a == B + 32'h08) return m_count;
        if (a == B + 32'h0C) return {16'd0, m_pres};
        if (a == B + 32'h10) return {31'd0, m_pend};
        return 32'd0;
    endfunction

    function automatic void model_edge(input bit rst, input bit we, input bit re,
                                       input logic [31:0] a, input logic [31:0] d);
        bit tick, expire;
        bit n_en, n_per, n_irq, n_pend;
        logic [31:0] n_count, n_reload;
        logic [15:0] n_pres, n_phase;
        if (rst) begin
            m_en = 0; m_per = 0; m_irq = 0; m_pend = 0;
            m_reload = 0; m_count = 0; m_rd = 0; m_pres = 0; m_phase = 0;
            return;
        end
        m_rd     = re ? m_read(a) : 32'd0;
        tick     = m_en && (m_phase == m_pres);
        expire   = 0;
        n_en = m_en; n_per = m_per; n_irq = m_irq; n_pend = m_pend;
        n_count = m_count; n_reload = m_reload; n_pres = m_pres;
        n_phase = (!m_en || tick || (we && a == B)) ? 16'd0 : m_phase + 16'd1;
        if (we && a == B + 32'h08) n_count = d;
        else if (tick) begin
            if (m_count >= 2) n_count = m_count - 1;
            else begin
                expire  = 1;
                n_count = m_per ? m_reload : 32'd0;
                if (!m_per) n_en = 0;
            end
        end
        if (we && a == B) begin n_en = d[0]; n_per = d[1]; n_irq = d[2]; end
        if (we && a == B + 32'h04) n_reload = d;
        if (we && a == B + 32'h0C) n_pres = d[15:0];
        if (we && a == B + 32'h10 && d[0]) n_pend = 0;
        if (expire) n_pend = 1;
        m_en = n_en; m_per = n_per; m_irq = n_irq; m_pend = n_pend;
        m_count = n_count; m_reload = n_reload; m_pres = n_pres; m_phase = n_phase;
    endfunction

    task automatic cycle(input bit rst, input bit we, input bit re,
                         input logic [31:0] a, input logic [31:0] d);
        reset          = rst;
        bus.write_en   = we;
        bus.read_en    = re;
        bus.address    = a;
        bus.write_data = d;
        @(posedge clk);
        model_edge(rst, we, re, a, d);
        #1;
        reset = 0; bus.write_en = 0; bus.read_en = 0; bus.address = 0; bus.write_data = 0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        cycle(0, 1, 0, B + off, d);
    endtask
    task automatic rd(input logic [31:0] off);
        cycle(0, 0, 1, B + off, 32'd0);
    endtask
    task automatic idle();
        cycle(0, 0, 0, 32'd0, 32'd0);
    endtask
    task automatic do_reset();
        cycle(1, 0, 0, 32'd0, 32'd0);
        cycle(1, 0, 0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (timer_interrupt !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b want 0", timer_interrupt);
        end
        n_cmp++;
        if (bus.read_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_read_data: got %h want 0", bus.read_data);
        end
        for (int i = 0; i < 5; i++) begin
            rd(32'(i * 4));
            n_cmp++;
            if (bus.read_data !== 32'd0) begin
                n_fail++; $display("FAIL reset_reg_%0d: got %h want 0", i * 4, bus.read_data);
            end
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        wr(32'h0C, 0); wr(32'h08, 3); wr(32'h00, 5);
        for (int k = 1; k <= 3; k++) begin
            idle();
            n_cmp++;
            if (timer_interrupt !== (k == 3)) begin
                n_fail++; $display("FAIL oneshot_irq_c%0d: got %b want %b", k, timer_interrupt, k == 3);
            end
        end
        rd(32'h00);
        n_cmp++;
        if (bus.read_data !== 32'h4) begin
            n_fail++; $display("FAIL oneshot_ctrl: got %h want 4", bus.read_data);
        end
        rd(32'h08);
        n_cmp++;
        if (bus.read_data !== 32'h0) begin
            n_fail++; $display("FAIL oneshot_count: got %h want 0", bus.read_data);
        end
        rd(32'h10);
        n_cmp++;
        if (bus.read_data !== 32'h1) begin
            n_fail++; $display("FAIL oneshot_pending: got %h want 1", bus.read_data);
        end
    endtask

    task automatic test_periodic();
        bit exp_irq;
        do_reset();
        wr(32'h0C, 3); wr(32'h04, 2); wr(32'h08, 2); wr(32'h00, 7);
        for (int k = 1; k <= 24; k++) begin
            if (k == 10) wr(32'h10, 1);
            else idle();
            exp_irq = (k >= 8 && k < 10) || (k >= 16);
            n_cmp++;
            if (timer_interrupt !== exp_irq) begin
                n_fail++; $display("FAIL periodic_irq_c%0d: got %b want %b", k, timer_interrupt, exp_irq);
            end
        end
    endtask

    task automatic test_read_timing();
        do_reset();
        wr(32'h0C, 0); wr(32'h08, 100); wr(32'h00, 1);
        rd(32'h08);
        n_cmp++;
        if (bus.read_data !== 32'd100) begin
            n_fail++; $display("FAIL read_count_first: got %0d want 100", bus.read_data);
        end
        rd(32'h08);
        n_cmp++;
        if (bus.read_data !== 32'd99) begin
            n_fail++; $display("FAIL read_count_second: got %0d want 99", bus.read_data);
        end
        rd(32'h14);
        n_cmp++;
        if (bus.read_data !== 32'd0) begin
            n_fail++; $display("FAIL read_unmapped: got %h want 0", bus.read_data);
        end
        cycle(0, 0, 0, B + 32'h08, 0);
        n_cmp++;
        if (bus.read_data !== 32'd0) begin
            n_fail++; $display("FAIL read_en_low: got %h want 0", bus.read_data);
        end
        cycle(0, 0, 1, B - 32'h4, 0);
        n_cmp++;
        if (bus.read_data !== 32'd0) begin
            n_fail++; $display("FAIL read_below_base: got %h want 0", bus.read_data);
        end
    endtask

    task automatic test_collision_count();
        do_reset();
        wr(32'h0C, 0); wr(32'h08, 50); wr(32'h00, 1);
        wr(32'h08, 7);
        rd(32'h08);
        n_cmp++;
        if (bus.read_data !== 32'd7) begin
            n_fail++; $display("FAIL collide_count: got %0d want 7", bus.read_data);
        end
        rd(32'h08);
        n_cmp++;
        if (bus.read_data !== 32'd6) begin
            n_fail++; $display("FAIL collide_count_after: got %0d want 6", bus.read_data);
        end
    endtask

    task automatic test_collision_status();
        do_reset();
        wr(32'h0C, 0); wr(32'h08, 2); wr(32'h00, 1);
        idle();
        wr(32'h10, 1);
        rd(32'h10);
        n_cmp++;
        if (bus.read_data !== 32'd1) begin
            n_fail++; $display("FAIL collide_status: got %h want 1", bus.read_data);
        end
        rd(32'h00);
        n_cmp++;
        if (bus.read_data !== 32'd0) begin
            n_fail++; $display("FAIL collide_status_ctrl: got %h want 0", bus.read_data);
        end
    endtask

    task automatic test_collision_ctrl();
        do_reset();
        wr(32'h0C, 0); wr(32'h08, 1); wr(32'h00, 1);
        wr(32'h00, 32'h6);
        n_cmp++;
        if (timer_interrupt !== 1'b1) begin
            n_fail++; $display("FAIL collide_ctrl_irq: got %b want 1", timer_interrupt);
        end
        rd(32'h00);
        n_cmp++;
        if (bus.read_data !== 32'h6) begin
            n_fail++; $display("FAIL collide_ctrl_value: got %h want 6", bus.read_data);
        end
    endtask

    task automatic test_irq_mask();
        do_reset();
        wr(32'h0C, 1); wr(32'h08, 1); wr(32'h00, 1);
        repeat (4) idle();
        n_cmp++;
        if (timer_interrupt !== 1'b0) begin
            n_fail++; $display("FAIL mask_irq_low: got %b want 0", timer_interrupt);
        end
        rd(32'h10);
        n_cmp++;
        if (bus.read_data !== 32'd1) begin
            n_fail++; $display("FAIL mask_pending: got %h want 1", bus.read_data);
        end
        wr(32'h00, 4);
        n_cmp++;
        if (timer_interrupt !== 1'b1) begin
            n_fail++; $display("FAIL mask_irq_unmask: got %b want 1", timer_interrupt);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        do_reset();
        wr(32'h0C, 2); wr(32'h04, 9); wr(32'h08, 5); wr(32'h00, 5);
        repeat (4) idle();
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 100; k++) begin
            idle();
            if (timer_interrupt !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL reset_mid_irq: got %0d interrupt cycles want 0", bad);
        end
        for (int i = 0; i < 5; i++) begin
            rd(32'(i * 4));
            n_cmp++;
            if (bus.read_data !== 32'd0) begin
                n_fail++; $display("FAIL reset_mid_reg_%0d: got %h want 0", i * 4, bus.read_data);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] offs [8];
        logic [31:0] off, d;
        int r;
        offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'hFFFF_FFFC, 32'h100};
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r   = $urandom_range(0, 99);
            off = offs[$urandom_range(0, 7)];
            if (r < 2) begin
                cycle(1, 0, 0, 0, 0);
            end else if (r < 40) begin
                case (off)
                    32'h0:   d = $urandom;
                    32'h4:   d = $urandom_range(0, 6);
                    32'h8:   d = $urandom_range(0, 6);
                    32'hC:   d = $urandom_range(0, 4);
                    32'h10:  d = $urandom_range(0, 1);
                    default: d = $urandom;
                endcase
                wr(off, d);
            end else if (r < 75) begin
                rd(off);
            end else begin
                cycle(0, 0, 0, B + off, $urandom);
            end
            n_cmp++;
            if (bus.read_data !== m_rd) begin
                n_fail++; $display("FAIL rand_read_data_%0d: got %h want %h", n, bus.read_data, m_rd);
            end
            n_cmp++;
            if (timer_interrupt !== (m_pend & m_irq)) begin
                n_fail++; $display("FAIL rand_irq_%0d: got %b want %b", n, timer_interrupt, m_pend & m_irq);
            end
        end
    endtask

    initial begin
        reset = 1; bus.write_en = 0; bus.read_en = 0; bus.address = 0; bus.write_data = 0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_read_timing();
        test_collision_count();
        test_collision_status();
        test_collision_ctrl();
        test_irq_mask();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/io_interval_timer.md
IO_INTERVAL_TIMER -- requirements
Module: io_interval_timer

Interface
REQ-001 Parameter BASE_ADDRESS, default 'h240, byte address of the first timer register on the IO bus.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 io_bus  io_bus_interface.slave  --  write_en, read_en, address[31:0], write_data[31:0] in; read_data[31:0] out.
REQ-005 timer_interrupt  output  1  level interrupt, intended for one bit of the processor interrupt_req vector.

Function
REQ-006 Register map, byte offsets from BASE_ADDRESS, word access only:
- +0x00 CTRL: bit0 enable, bit1 periodic, bit2 irq_enable; other bits read 0.
- +0x04 RELOAD: 32 bits.
- +0x08 COUNT: 32 bits.
- +0x0C PRESCALE: bits [15:0].
- +0x10 STATUS: bit0 pending; writing 1 clears it, writing 0 has no effect.
REQ-007 Writes to addresses outside BASE_ADDRESS..BASE_ADDRESS+0x10 shall change no state.
REQ-008 Read latency shall be 1 cycle: read_data, registered, reflects the addressed register in the cycle after read_en.
REQ-009 Reads of unmapped offsets, of addresses outside the block, or with read_en low shall return 0 in the following cycle.
REQ-010 Reads shall have no side effects.
REQ-011 Prescaler: 16-bit counter.
- While enable=1: increments each cycle; on reaching PRESCALE it produces a one-cycle tick and returns to 0.
- A tick therefore occurs every PRESCALE+1 cycles.
REQ-012 While enable=0 the prescaler shall be held at 0 and no ticks shall occur.
REQ-013 On a tick with COUNT>1: COUNT decrements by 1.
REQ-014 On a tick with COUNT==1 or COUNT==0 (expiry):
- pending is set;
- if periodic=1, COUNT loads RELOAD;
- if periodic=0, COUNT becomes 0 and enable clears.
REQ-015 COUNT arithmetic shall be 32-bit unsigned; COUNT shall never wrap below 0.
REQ-016 timer_interrupt shall equal pending AND irq_enable, driven from registered state (no combinational path from io_bus).
REQ-017 A CTRL write clearing enable shall reset the prescaler in the same edge.
- A CTRL write setting enable shall start the prescaler from 0, so the first tick occurs PRESCALE+1 cycles later.
REQ-018 Simultaneous events: a software COUNT write in the same cycle as a tick shall win; the written value is loaded and no decrement or expiry occurs.
REQ-019 Simultaneous events: a STATUS clear in the same cycle as an expiry shall leave pending set (set wins).
REQ-020 Simultaneous events: a CTRL write in the same cycle as a one-shot expiry shall take the written CTRL value; pending is still set.
REQ-021 Changing PRESCALE while running shall take effect at the next compare; if the prescaler is already above the new value, it continues to 16'hFFFF, wraps to 0, then compares normally.
REQ-022 Implementation size target: 120-400 lines of RTL.

Reset
REQ-023 On reset, in the same edge:
- CTRL, RELOAD, COUNT, PRESCALE, pending, prescaler and read_data all become 0;
- timer_interrupt is 0 from the next cycle.
REQ-024 Reset asserted mid-count shall abandon the count; no expiry shall be reported for it.

Verification
REQ-025 One-shot: PRESCALE=0, COUNT=3, CTRL=0x5 -> pending and timer_interrupt rise exactly 3 cycles after the CTRL write edge; enable then reads 0 and COUNT reads 0.
REQ-026 Periodic: PRESCALE=3, RELOAD=COUNT=2, CTRL=0x7 -> pending set every 8 cycles; write STATUS=1 between expiries -> timer_interrupt drops for 1+ cycles, then reasserts at the next expiry.
REQ-027 Read timing: read_en at COUNT address in cycle N -> read_data holds the cycle-N COUNT value in cycle N+1; read of BASE+0x14 -> 0.
REQ-028 Collisions, each checked separately:
- COUNT write coincident with a tick -> COUNT equals the written value, no decrement;
- STATUS clear coincident with an expiry -> pending remains 1.
REQ-029 irq masking: expiry with irq_enable=0 -> pending=1, timer_interrupt=0; then set irq_enable -> timer_interrupt=1 the next cycle.
REQ-030 Reset mid-operation: assert reset with COUNT=5 while running -> all registers read 0, no interrupt occurs over 100 following cycles.
